// File: rtl/hazard_unit_pkg.sv
// Shared encodings for the MIPS hazard unit: opcode/funct values, Tuse/Tnew
// constants, forwarding select encoding and the decoded instruction classes.
package hazard_unit_pkg;

  localparam logic [5:0] OP_SPECIAL = 6'h00;
  localparam logic [5:0] OP_JAL     = 6'h03;
  localparam logic [5:0] OP_BEQ     = 6'h04;
  localparam logic [5:0] OP_ADDI    = 6'h08;
  localparam logic [5:0] OP_ORI     = 6'h0D;
  localparam logic [5:0] OP_LUI     = 6'h0F;
  localparam logic [5:0] OP_LW      = 6'h23;
  localparam logic [5:0] OP_SW      = 6'h2B;

  localparam logic [5:0] FN_JR    = 6'h08;
  localparam logic [5:0] FN_JALR  = 6'h09;
  localparam logic [5:0] FN_MFHI  = 6'h10;
  localparam logic [5:0] FN_MTHI  = 6'h11;
  localparam logic [5:0] FN_MFLO  = 6'h12;
  localparam logic [5:0] FN_MTLO  = 6'h13;
  localparam logic [5:0] FN_MULT  = 6'h18;
  localparam logic [5:0] FN_MULTU = 6'h19;
  localparam logic [5:0] FN_DIV   = 6'h1A;
  localparam logic [5:0] FN_DIVU  = 6'h1B;
  localparam logic [5:0] FN_ADDU  = 6'h21;
  localparam logic [5:0] FN_SUBU  = 6'h23;

  // Tuse: cycles after D before a source is consumed; Tnew: cycles after E
  // before a result exists.
  localparam int TUSE_EARLY = 0;
  localparam int TUSE_ALU   = 1;
  localparam int TNEW_NOW   = 0;
  localparam int TNEW_ALU   = 1;
  localparam int TNEW_LOAD  = 2;

  localparam int FWD_REGFILE = 0;

  localparam logic [4:0] REG_ZERO = 5'd0;
  localparam logic [4:0] REG_RA   = 5'd31;

  typedef enum logic [3:0] {
    CL_NOP,
    CL_ALU_R,
    CL_ALU_I,
    CL_LOAD,
    CL_STORE,
    CL_BRANCH,
    CL_JR,
    CL_JAL,
    CL_JALR,
    CL_MFHL,
    CL_MTHL,
    CL_MULT,
    CL_DIV
  } instr_class_e;

endpackage

// File: rtl/hazard_unit_decode.sv
// Combinational D-stage decoder: classifies the instruction and reports its
// source registers with Tuse, its destination with Tnew, and HI/LO usage.
module hazard_unit_decode
  import hazard_unit_pkg::*;
#(
  parameter int TW       = 2,
  parameter int CW       = 4,
  parameter int MULT_LAT = 5,
  parameter int DIV_LAT  = 10
) (
  input  logic [31:0]   i_instr,
  output logic [4:0]    o_rs,
  output logic [4:0]    o_rt,
  output logic [4:0]    o_dst,
  output logic [TW-1:0] o_tnew,
  output logic [TW-1:0] o_tuse_rs,
  output logic [TW-1:0] o_tuse_rt,
  output logic          o_is_mdu,
  output logic          o_mdu_start,
  output logic [CW-1:0] o_mdu_lat
);

  instr_class_e w_class;
  logic [5:0]   w_op;
  logic [5:0]   w_fn;
  logic [4:0]   w_rs;
  logic [4:0]   w_rt;
  logic [4:0]   w_rd;
  logic         w_shamt_zero;

  assign w_op         = i_instr[31:26];
  assign w_rs         = i_instr[25:21];
  assign w_rt         = i_instr[20:16];
  assign w_rd         = i_instr[15:11];
  assign w_shamt_zero = (i_instr[10:6] == 5'd0);
  assign w_fn         = i_instr[5:0];

  // R-type with a nonzero shamt is not one of the tracked forms, so it is a nop.
  always_comb begin
    w_class = CL_NOP;
    case (w_op)
      OP_SPECIAL: begin
        if (w_shamt_zero) begin
          case (w_fn)
            FN_ADDU, FN_SUBU:                   w_class = CL_ALU_R;
            FN_JR:                              w_class = CL_JR;
            FN_JALR:                            w_class = CL_JALR;
            FN_MFHI, FN_MFLO:                   w_class = CL_MFHL;
            FN_MTHI, FN_MTLO:                   w_class = CL_MTHL;
            FN_MULT, FN_MULTU:                  w_class = CL_MULT;
            FN_DIV, FN_DIVU:                    w_class = CL_DIV;
            default:                            w_class = CL_NOP;
          endcase
        end
      end
      OP_ORI, OP_LUI, OP_ADDI: w_class = CL_ALU_I;
      OP_LW:                   w_class = CL_LOAD;
      OP_SW:                   w_class = CL_STORE;
      OP_BEQ:                  w_class = CL_BRANCH;
      OP_JAL:                  w_class = CL_JAL;
      default:                 w_class = CL_NOP;
    endcase
  end

  // Unused sources are reported as $0 so they can never match a writer.
  always_comb begin
    o_rs        = REG_ZERO;
    o_rt        = REG_ZERO;
    o_dst       = REG_ZERO;
    o_tnew      = TW'(TNEW_NOW);
    o_tuse_rs   = TW'(TUSE_EARLY);
    o_tuse_rt   = TW'(TUSE_EARLY);
    o_is_mdu    = 1'b0;
    o_mdu_start = 1'b0;
    o_mdu_lat   = '0;
    case (w_class)
      CL_ALU_R: begin
        o_rs = w_rs; o_rt = w_rt; o_dst = w_rd; o_tnew = TW'(TNEW_ALU);
        o_tuse_rs = TW'(TUSE_ALU); o_tuse_rt = TW'(TUSE_ALU);
      end
      CL_ALU_I: begin
        o_rs = w_rs; o_tuse_rs = TW'(TUSE_ALU); o_dst = w_rt; o_tnew = TW'(TNEW_ALU);
      end
      CL_LOAD: begin
        o_rs = w_rs; o_tuse_rs = TW'(TUSE_ALU); o_dst = w_rt; o_tnew = TW'(TNEW_LOAD);
      end
      CL_STORE: begin
        o_rs = w_rs; o_rt = w_rt; o_tuse_rs = TW'(TUSE_ALU); o_tuse_rt = TW'(TUSE_ALU);
      end
      CL_BRANCH: begin
        o_rs = w_rs; o_rt = w_rt; o_tuse_rs = TW'(TUSE_EARLY); o_tuse_rt = TW'(TUSE_EARLY);
      end
      CL_JR: begin
        o_rs = w_rs; o_tuse_rs = TW'(TUSE_EARLY);
      end
      CL_JAL: begin
        o_dst = REG_RA; o_tnew = TW'(TNEW_NOW);
      end
      CL_JALR: begin
        o_rs = w_rs; o_tuse_rs = TW'(TUSE_EARLY); o_dst = w_rd; o_tnew = TW'(TNEW_NOW);
      end
      CL_MFHL: begin
        o_dst = w_rd; o_tnew = TW'(TNEW_ALU); o_is_mdu = 1'b1;
      end
      CL_MTHL: begin
        o_rs = w_rs; o_tuse_rs = TW'(TUSE_ALU); o_is_mdu = 1'b1;
      end
      CL_MULT: begin
        o_rs = w_rs; o_rt = w_rt; o_tuse_rs = TW'(TUSE_ALU); o_tuse_rt = TW'(TUSE_ALU);
        o_is_mdu = 1'b1; o_mdu_start = 1'b1; o_mdu_lat = CW'(MULT_LAT);
      end
      CL_DIV: begin
        o_rs = w_rs; o_rt = w_rt; o_tuse_rs = TW'(TUSE_ALU); o_tuse_rt = TW'(TUSE_ALU);
        o_is_mdu = 1'b1; o_mdu_start = 1'b1; o_mdu_lat = CW'(DIV_LAT);
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/hazard_unit.sv
// Stall/forward controller for the 5-stage MIPS pipeline: a scoreboard of
// in-flight writers (E..W), nearest-match priority, and an HI/LO busy counter.
module hazard_unit
  import hazard_unit_pkg::*;
#(
  parameter int STAGES   = 3,
  parameter int MULT_LAT = 5,
  parameter int DIV_LAT  = 10,
  parameter int TW       = 2
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [31:0]                  instr_d,
  output logic                         stall,
  output logic [$clog2(STAGES+1)-1:0]  fwd_rs_d,
  output logic [$clog2(STAGES+1)-1:0]  fwd_rt_d,
  output logic [$clog2(STAGES+1)-1:0]  fwd_rs_e,
  output logic [$clog2(STAGES+1)-1:0]  fwd_rt_e,
  output logic                         mdu_busy
);

  localparam int FW      = $clog2(STAGES + 1);
  localparam int MAX_LAT = (MULT_LAT > DIV_LAT) ? MULT_LAT : DIV_LAT;
  localparam int CW      = $clog2(MAX_LAT + 1);
  localparam int HW      = 1 + FW + TW;

  logic [4:0]    w_rs;
  logic [4:0]    w_rt;
  logic [4:0]    w_dst;
  logic [TW-1:0] w_tnew;
  logic [TW-1:0] w_tuse_rs;
  logic [TW-1:0] w_tuse_rt;
  logic          w_is_mdu;
  logic          w_mdu_start;
  logic [CW-1:0] w_mdu_lat;

  logic [4:0]    r_dst  [1:STAGES];
  logic [TW-1:0] r_tnew [1:STAGES];
  logic [4:0]    r_e_rs;
  logic [4:0]    r_e_rt;
  logic          r_e_start;
  logic [CW-1:0] r_e_lat;
  logic [CW-1:0] r_busy_cnt;

  hazard_unit_decode #(
    .TW       (TW),
    .CW       (CW),
    .MULT_LAT (MULT_LAT),
    .DIV_LAT  (DIV_LAT)
  ) u_decode (
    .i_instr     (instr_d),
    .o_rs        (w_rs),
    .o_rt        (w_rt),
    .o_dst       (w_dst),
    .o_tnew      (w_tnew),
    .o_tuse_rs   (w_tuse_rs),
    .o_tuse_rt   (w_tuse_rt),
    .o_is_mdu    (w_is_mdu),
    .o_mdu_start (w_mdu_start),
    .o_mdu_lat   (w_mdu_lat)
  );

  // A stalled D instruction turns into a bubble in E; the counter still loads
  // from whatever mult/div already sits in E.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 1; k <= STAGES; k++) begin
        r_dst[k]  <= REG_ZERO;
        r_tnew[k] <= '0;
      end
      r_e_rs     <= REG_ZERO;
      r_e_rt     <= REG_ZERO;
      r_e_start  <= 1'b0;
      r_e_lat    <= '0;
      r_busy_cnt <= '0;
    end else begin
      for (int k = STAGES; k >= 2; k--) begin
        r_dst[k]  <= r_dst[k-1];
        r_tnew[k] <= (r_tnew[k-1] != '0) ? r_tnew[k-1] - TW'(1) : '0;
      end
      if (stall) begin
        r_dst[1]  <= REG_ZERO;
        r_tnew[1] <= '0;
        r_e_rs    <= REG_ZERO;
        r_e_rt    <= REG_ZERO;
        r_e_start <= 1'b0;
        r_e_lat   <= '0;
      end else begin
        r_dst[1]  <= w_dst;
        r_tnew[1] <= w_tnew;
        r_e_rs    <= w_rs;
        r_e_rt    <= w_rt;
        r_e_start <= w_mdu_start;
        r_e_lat   <= w_mdu_lat;
      end
      if (r_e_start) begin
        r_busy_cnt <= r_e_lat;
      end else if (r_busy_cnt != '0) begin
        r_busy_cnt <= r_busy_cnt - CW'(1);
      end
    end
  end

  // Returns {found, stage, tnew}; scanning far-to-near lets the nearest writer win.
  function automatic logic [HW-1:0] nearest(input logic [4:0] src, input int kmin);
    logic [HW-1:0] hit;
    hit = '0;
    for (int k = STAGES; k >= 1; k--) begin
      if (k >= kmin && r_dst[k] != REG_ZERO && r_dst[k] == src) begin
        hit = {1'b1, FW'(k), r_tnew[k]};
      end
    end
    return hit;
  endfunction

  function automatic logic [FW-1:0] fwd_sel(input logic [HW-1:0] hit);
    return (hit[HW-1] && hit[TW-1:0] == '0) ? hit[TW +: FW] : FW'(FWD_REGFILE);
  endfunction

  logic [HW-1:0] w_hit_rs_d;
  logic [HW-1:0] w_hit_rt_d;
  logic [HW-1:0] w_hit_rs_e;
  logic [HW-1:0] w_hit_rt_e;
  logic          w_data_stall;
  logic          w_mdu_stall;

  always_comb begin
    w_hit_rs_d = nearest(w_rs, 1);
    w_hit_rt_d = nearest(w_rt, 1);
    w_hit_rs_e = nearest(r_e_rs, 2);
    w_hit_rt_e = nearest(r_e_rt, 2);
  end

  assign w_data_stall = (w_hit_rs_d[HW-1] && (w_tuse_rs < w_hit_rs_d[TW-1:0])) ||
                        (w_hit_rt_d[HW-1] && (w_tuse_rt < w_hit_rt_d[TW-1:0]));
  assign w_mdu_stall  = w_is_mdu && (mdu_busy || r_e_start);

  assign stall    = w_data_stall || w_mdu_stall;
  assign mdu_busy = (r_busy_cnt != '0);
  assign fwd_rs_d = fwd_sel(w_hit_rs_d);
  assign fwd_rt_d = fwd_sel(w_hit_rt_d);
  assign fwd_rs_e = fwd_sel(w_hit_rs_e);
  assign fwd_rt_e = fwd_sel(w_hit_rt_e);

endmodule

// File: tb/tb_hazard_unit.sv
// Directed bench for hazard_unit: instruction sequences with hand-derived
// stall, forwarding and HI/LO busy expectations (STAGES=3, MULT_LAT=5, DIV_LAT=10).
module tb_hazard_unit;

  logic        clk;
  logic        reset;
  logic [31:0] instr_d;
  logic        stall;
  logic [1:0]  fwd_rs_d;
  logic [1:0]  fwd_rt_d;
  logic [1:0]  fwd_rs_e;
  logic [1:0]  fwd_rt_e;
  logic        mdu_busy;

  int vectors = 0;
  int miscompares = 0;

  localparam logic [31:0] NOP = 32'h0000_0000;

  hazard_unit #(.STAGES(3), .MULT_LAT(5), .DIV_LAT(10), .TW(2)) dut (
    .clk      (clk),
    .reset    (reset),
    .instr_d  (instr_d),
    .stall    (stall),
    .fwd_rs_d (fwd_rs_d),
    .fwd_rt_d (fwd_rt_d),
    .fwd_rs_e (fwd_rs_e),
    .fwd_rt_e (fwd_rt_e),
    .mdu_busy (mdu_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [31:0] rType(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [5:0] fn);
    return {6'h00, rs, rt, rd, 5'd0, fn};
  endfunction

  function automatic logic [31:0] iType(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  // Inputs change 1ns after the rising edge; outputs are sampled at the falling edge.
  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic applyReset();
    instr_d = NOP;
    reset = 1'b1;
    nextCycle();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    instr_d = NOP;
    reset = 1'b1;
    nextCycle();
    nextCycle();
    @(negedge clk);
    vectors++; if (stall !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_stall: got %0b want 0", stall); end
    vectors++; if (fwd_rs_d !== 2'd0) begin miscompares++; $display("[TB] FAIL reset_fwd_rs_d: got %0d want 0", fwd_rs_d); end
    vectors++; if (fwd_rt_d !== 2'd0) begin miscompares++; $display("[TB] FAIL reset_fwd_rt_d: got %0d want 0", fwd_rt_d); end
    vectors++; if (fwd_rs_e !== 2'd0) begin miscompares++; $display("[TB] FAIL reset_fwd_rs_e: got %0d want 0", fwd_rs_e); end
    vectors++; if (fwd_rt_e !== 2'd0) begin miscompares++; $display("[TB] FAIL reset_fwd_rt_e: got %0d want 0", fwd_rt_e); end
    vectors++; if (mdu_busy !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_mdu_busy: got %0b want 0", mdu_busy); end
    nextCycle();
    reset = 1'b0;
  endtask

  // lw $1 (Tnew 2) feeding addu $2,$1,$1 (Tuse 1): one bubble, then the load
  // has reached W by the time addu is in E.
  task automatic test_load_use();
    applyReset();
    instr_d = iType(6'h23, 5'd0, 5'd1, 16'h0010);
    @(negedge clk);
    vectors++; if (stall !== 1'b0) begin miscompares++; $display("[TB] FAIL lu_lw_no_stall: got %0b want 0", stall); end
    nextCycle();
    instr_d = rType(5'd1, 5'd1, 5'd2, 6'h21);
    @(negedge clk);
    vectors++; if (stall !== 1'b1) begin miscompares++; $display("[TB] FAIL lu_stall_first: got %0b want 1", stall); end
    nextCycle();
    @(negedge clk);
    vectors++; if (stall !== 1'b0) begin miscompares++; $display("[TB] FAIL lu_release: got %0b want 0", stall); end
    vectors++; if (fwd_rs_d !== 2'd0) begin miscompares++; $display("[TB] FAIL lu_fwd_rs_d_notready: got %0d want 0", fwd_rs_d); end
    nextCycle();
    instr_d = NOP;
    @(negedge clk);
    vectors++; if (fwd_rs_e !== 2'd3) begin miscompares++; $display("[TB] FAIL lu_fwd_rs_e: got %0d want 3", fwd_rs_e); end
    vectors++; if (fwd_rt_e !== 2'd3) begin miscompares++; $display("[TB] FAIL lu_fwd_rt_e: got %0d want 3", fwd_rt_e); end
  endtask

  task automatic test_branch();
    applyReset();
    instr_d = rType(5'd1, 5'd2, 5'd3, 6'h21);
    nextCycle();
    instr_d = iType(6'h04, 5'd3, 5'd0, 16'h0004);
    @(negedge clk);
    vectors++; if (stall !== 1'b1) begin miscompares++; $display("[TB] FAIL br_stall: got %0b want 1", stall); end
    nextCycle();
    @(negedge clk);
    vectors++; if (stall !== 1'b0) begin miscompares++; $display("[TB] FAIL br_release: got %0b want 0", stall); end
    vectors++; if (fwd_rs_d !== 2'd2) begin miscompares++; $display("[TB] FAIL br_fwd_rs_d: got %0d want 2", fwd_rs_d); end
    vectors++; if (fwd_rt_d !== 2'd0) begin miscompares++; $display("[TB] FAIL br_fwd_rt_d_zero: got %0d want 0", fwd_rt_d); end
  endtask

  task automatic test_jal_jr();
    applyReset();
    instr_d = {6'h03, 26'h0000040};
    nextCycle();
    instr_d = rType(5'd31, 5'd0, 5'd0, 6'h08);
    @(negedge clk);
    vectors++; if (stall !== 1'b0) begin miscompares++; $display("[TB] FAIL jr_stall: got %0b want 0", stall); end
    vectors++; if (fwd_rs_d !== 2'd1) begin miscompares++; $display("[TB] FAIL jr_fwd_rs_d: got %0d want 1", fwd_rs_d); end
  endtask

  // lw $4 then ori $4: the younger writer must shadow the load at every stage.
  task automatic test_nearest();
    applyReset();
    instr_d = iType(6'h23, 5'd0, 5'd4, 16'h0000);
    nextCycle();
    instr_d = iType(6'h0D, 5'd0, 5'd4, 16'h0005);
    @(negedge clk);
    vectors++; if (stall !== 1'b0) begin miscompares++; $display("[TB] FAIL nr_ori_stall: got %0b want 0", stall); end
    nextCycle();
    instr_d = iType(6'h2B, 5'd0, 5'd4, 16'h0000);
    @(negedge clk);
    vectors++; if (stall !== 1'b0) begin miscompares++; $display("[TB] FAIL nr_sw_stall: got %0b want 0", stall); end
    vectors++; if (fwd_rt_d !== 2'd0) begin miscompares++; $display("[TB] FAIL nr_sw_fwd_rt_d: got %0d want 0", fwd_rt_d); end
    nextCycle();
    instr_d = iType(6'h04, 5'd4, 5'd0, 16'h0000);
    @(negedge clk);
    vectors++; if (fwd_rt_e !== 2'd2) begin miscompares++; $display("[TB] FAIL nr_sw_fwd_rt_e: got %0d want 2", fwd_rt_e); end
    vectors++; if (fwd_rs_e !== 2'd0) begin miscompares++; $display("[TB] FAIL nr_sw_fwd_rs_e: got %0d want 0", fwd_rs_e); end
    vectors++; if (fwd_rs_d !== 2'd2) begin miscompares++; $display("[TB] FAIL nr_beq_fwd_rs_d: got %0d want 2", fwd_rs_d); end
    vectors++; if (stall !== 1'b0) begin miscompares++; $display("[TB] FAIL nr_beq_stall: got %0b want 0", stall); end
  endtask

  task automatic test_rs_eq_rt();
    applyReset();
    instr_d = rType(5'd1, 5'd2, 5'd5, 6'h23);
    nextCycle();
    instr_d = NOP;
    nextCycle();
    instr_d = iType(6'h04, 5'd5, 5'd5, 16'h0000);
    @(negedge clk);
    vectors++; if (stall !== 1'b0) begin miscompares++; $display("[TB] FAIL rr_stall: got %0b want 0", stall); end
    vectors++; if (fwd_rs_d !== 2'd2) begin miscompares++; $display("[TB] FAIL rr_fwd_rs_d: got %0d want 2", fwd_rs_d); end
    vectors++; if (fwd_rt_d !== 2'd2) begin miscompares++; $display("[TB] FAIL rr_fwd_rt_d: got %0d want 2", fwd_rt_d); end
  endtask

  // Start an HI/LO op, then hold an HI/LO reader in D and count stall/busy cycles.
  task automatic test_mdu(input string name, input logic [5:0] startFn,
                          input logic [5:0] readFn, input int wantStall, input int wantBusy);
    int stallCnt;
    int busyCnt;
    bit released;
    applyReset();
    instr_d = rType(5'd1, 5'd2, 5'd0, startFn);
    nextCycle();
    instr_d = rType(5'd0, 5'd0, 5'd7, readFn);
    stallCnt = 0;
    busyCnt = 0;
    released = 1'b0;
    for (int i = 0; i < 40 && !released; i++) begin
      @(negedge clk);
      if (mdu_busy === 1'b1) busyCnt++;
      if (stall === 1'b1) begin
        stallCnt++;
        nextCycle();
      end else begin
        released = 1'b1;
      end
    end
    vectors++; if (released !== 1'b1) begin miscompares++; $display("[TB] FAIL %s_release_timeout: got %0b want 1", name, released); end
    vectors++; if (stallCnt != wantStall) begin miscompares++; $display("[TB] FAIL %s_stall_cycles: got %0d want %0d", name, stallCnt, wantStall); end
    vectors++; if (busyCnt != wantBusy) begin miscompares++; $display("[TB] FAIL %s_busy_cycles: got %0d want %0d", name, busyCnt, wantBusy); end
  endtask

  task automatic test_reset_mid_stall();
    applyReset();
    instr_d = rType(5'd1, 5'd2, 5'd0, 6'h18);
    nextCycle();
    instr_d = iType(6'h23, 5'd0, 5'd1, 16'h0000);
    nextCycle();
    instr_d = rType(5'd1, 5'd1, 5'd2, 6'h21);
    reset = 1'b1;
    @(negedge clk);
    vectors++; if (stall !== 1'b1) begin miscompares++; $display("[TB] FAIL rm_stall_before: got %0b want 1", stall); end
    vectors++; if (mdu_busy !== 1'b1) begin miscompares++; $display("[TB] FAIL rm_busy_before: got %0b want 1", mdu_busy); end
    nextCycle();
    reset = 1'b0;
    @(negedge clk);
    vectors++; if (stall !== 1'b0) begin miscompares++; $display("[TB] FAIL rm_stall_after: got %0b want 0", stall); end
    vectors++; if (mdu_busy !== 1'b0) begin miscompares++; $display("[TB] FAIL rm_busy_after: got %0b want 0", mdu_busy); end
    vectors++; if ({fwd_rs_d, fwd_rt_d, fwd_rs_e, fwd_rt_e} !== 8'h00) begin
      miscompares++;
      $display("[TB] FAIL rm_fwd_after: got %0d/%0d/%0d/%0d want 0/0/0/0", fwd_rs_d, fwd_rt_d, fwd_rs_e, fwd_rt_e);
    end
  endtask

  initial begin
    reset = 1'b1;
    instr_d = NOP;
    test_reset();
    test_load_use();
    test_branch();
    test_jal_jr();
    test_nearest();
    test_rs_eq_rt();
    test_mdu("mult", 6'h18, 6'h12, 6, 5);
    test_mdu("div", 6'h1A, 6'h10, 11, 10);
    test_reset_mid_stall();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
